// File: rtl/card_payment_responder.sv
// Card payment responder: authorises the vending controller's COST against a stored
// balance, holds VALID_TRAN, and debits on VEND. Define TXN_COUNT_EN to add the debit counter.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no card; operator credit top-up accepted here only
// CARD_WAIT | card present, waiting for a non-zero COST (timeout -> decline)
// AUTH      | cost captured, AUTH_LAT cycles then funds decision
// GRANT     | VALID_TRAN held; waiting for VEND / FAILED_TRAN / timeout
// REMOVE    | transaction over, waiting for the card to be withdrawn
module card_payment_responder #(
   parameter int BAL_W     = 8,
   parameter int AUTH_LAT  = 2,
   parameter int COST_TMO  = 8,
   parameter int GRANT_TMO = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_card_in,
   input  logic [2:0]       i_cost,
   input  logic             i_vend,
   input  logic             i_failed_tran,
   input  logic             i_credit_load,
   input  logic [BAL_W-1:0] i_credit_amt,
`ifdef TXN_COUNT_EN
   input  logic             i_txn_clr,
   output logic [7:0]       o_txn_count,
`endif
   output logic             o_valid_tran,
   output logic             o_declined,
   output logic [BAL_W-1:0] o_balance,
   output logic             o_busy
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] L_COST_LD  = CNT_W'(COST_TMO - 1);
   localparam logic [CNT_W-1:0] L_AUTH_LD  = CNT_W'(AUTH_LAT);
   localparam logic [CNT_W-1:0] L_GRANT_LD = CNT_W'(GRANT_TMO - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CARD_WAIT = 3'd1,
      S_AUTH      = 3'd2,
      S_GRANT     = 3'd3,
      S_REMOVE    = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_cost_q;
   logic [BAL_W-1:0] r_balance;
   logic             r_valid;
   logic             r_declined;
   logic             w_decline;
   logic             w_debit;
   logic             w_capture;
   logic             w_funds_ok;
   logic [BAL_W:0]   w_sum;

   assign w_funds_ok = ({{(BAL_W-3){1'b0}}, r_cost_q} <= r_balance);
   assign w_sum      = {1'b0, r_balance} + {1'b0, i_credit_amt};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Card withdrawal aborts silently and takes priority over every other exit.
   always_comb begin
      w_state_nxt = r_state;
      w_decline   = 1'b0;
      w_debit     = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_card_in) w_state_nxt = S_CARD_WAIT;
         end
         S_CARD_WAIT: begin
            if (!i_card_in) w_state_nxt = S_IDLE;
            else if (i_cost != 3'd0) begin
               w_state_nxt = S_AUTH;
               w_capture   = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_REMOVE;
               w_decline   = 1'b1;
            end
         end
         S_AUTH: begin
            if (!i_card_in) w_state_nxt = S_IDLE;
            else if (r_cnt == '0) begin
               if (w_funds_ok) w_state_nxt = S_GRANT;
               else begin
                  w_state_nxt = S_REMOVE;
                  w_decline   = 1'b1;
               end
            end
         end
         S_GRANT: begin
            if (!i_card_in) w_state_nxt = S_IDLE;
            else if (i_vend) begin
               w_state_nxt = S_REMOVE;
               w_debit     = 1'b1;
            end else if (i_failed_tran) w_state_nxt = S_REMOVE;
            else if (r_cnt == '0) begin
               w_state_nxt = S_REMOVE;
               w_decline   = 1'b1;
            end
         end
         S_REMOVE: begin
            if (!i_card_in) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_valid_tran = r_valid;
      o_declined   = r_declined;
      o_balance    = r_balance;
      o_busy       = (r_state != S_IDLE);
   end

   // One shared down-counter, reloaded on every state change.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_cost_q   <= '0;
         r_balance  <= '0;
         r_valid    <= 1'b0;
         r_declined <= 1'b0;
      end else begin
         r_valid    <= (w_state_nxt == S_GRANT);
         r_declined <= w_decline;
         if (w_state_nxt != r_state) begin
            case (w_state_nxt)
               S_CARD_WAIT: r_cnt <= L_COST_LD;
               S_AUTH:      r_cnt <= L_AUTH_LD;
               S_GRANT:     r_cnt <= L_GRANT_LD;
               default:     r_cnt <= '0;
            endcase
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_capture) r_cost_q <= i_cost;
         if (w_debit) begin
            r_balance <= r_balance - {{(BAL_W-3){1'b0}}, r_cost_q};
         end else if (r_state == S_IDLE && i_credit_load) begin
            r_balance <= w_sum[BAL_W] ? {BAL_W{1'b1}} : w_sum[BAL_W-1:0];
         end
      end
   end

`ifdef TXN_COUNT_EN
   logic [7:0] r_txn_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                            r_txn_count <= 8'd0;
      else if (i_txn_clr)                      r_txn_count <= 8'd0;
      else if (w_debit && r_txn_count != 8'hFF) r_txn_count <= r_txn_count + 8'd1;
   end

   assign o_txn_count = r_txn_count;
`endif

endmodule

// File: tb/tb_card_payment_responder.sv
// Directed bench for card_payment_responder; define TXN_COUNT_EN to exercise the debit counter.
module tb_card_payment_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       card_in;
   logic [2:0] cost;
   logic       vend;
   logic       failed_tran;
   logic       credit_load;
   logic [7:0] credit_amt;
   logic       valid_tran;
   logic       declined;
   logic [7:0] balance;
   logic       busy;
`ifdef TXN_COUNT_EN
   logic       txn_clr;
   logic [7:0] txn_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   card_payment_responder dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_card_in     (card_in),
      .i_cost        (cost),
      .i_vend        (vend),
      .i_failed_tran (failed_tran),
      .i_credit_load (credit_load),
      .i_credit_amt  (credit_amt),
`ifdef TXN_COUNT_EN
      .i_txn_clr     (txn_clr),
      .o_txn_count   (txn_count),
`endif
      .o_valid_tran  (valid_tran),
      .o_declined    (declined),
      .o_balance     (balance),
      .o_busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      card_in     = 1'b0;
      cost        = 3'd0;
      vend        = 1'b0;
      failed_tran = 1'b0;
      credit_load = 1'b0;
      credit_amt  = 8'd0;
`ifdef TXN_COUNT_EN
      txn_clr     = 1'b0;
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic load(input logic [7:0] amt);
      credit_load = 1'b1;
      credit_amt  = amt;
      tick();
      credit_load = 1'b0;
      credit_amt  = 8'd0;
   endtask

   // Insert card, present cost, and step to the first GRANT cycle.
   task automatic go_grant(input logic [2:0] c);
      card_in = 1'b1;
      cost    = 3'd0;
      tick();
      cost = c;
      repeat (4) tick();
      chk("grant_valid", valid_tran, 1);
   endtask

   task automatic card_out();
      card_in = 1'b0;
      cost    = 3'd0;
      tick();
   endtask

   initial begin
      // basic authorise + vend
      do_reset();
      chk("rst_valid", valid_tran, 0);
      chk("rst_declined", declined, 0);
      chk("rst_balance", balance, 0);
      chk("rst_busy", busy, 0);
      load(8'd10);
      chk("load10", balance, 10);
      chk("load_busy", busy, 0);
      card_in = 1'b1;
      tick();
      chk("cw_busy", busy, 1);
      cost = 3'd3;
      tick();
      chk("lat_n0", valid_tran, 0);
      tick();
      chk("lat_n1", valid_tran, 0);
      tick();
      chk("lat_n2", valid_tran, 0);
      tick();
      chk("lat_n3", valid_tran, 1);
      chk("lat_n3_decl", declined, 0);
      cost = 3'd7;
      vend = 1'b1;
      tick();
      vend = 1'b0;
      chk("vend_valid", valid_tran, 0);
      chk("vend_balance", balance, 7);
      chk("remove_busy", busy, 1);
      card_out();
      chk("idle_busy", busy, 0);

      // insufficient funds
      do_reset();
      load(8'd4);
      card_in = 1'b1;
      tick();
      cost = 3'd6;
      tick();
      tick();
      tick();
      chk("nsf_pre_decl", declined, 0);
      tick();
      chk("nsf_decl", declined, 1);
      chk("nsf_valid", valid_tran, 0);
      tick();
      chk("nsf_decl_end", declined, 0);
      chk("nsf_balance", balance, 4);
      repeat (3) tick();
      chk("nsf_busy", busy, 1);
      card_out();
      chk("nsf_idle", busy, 0);

      // saturation
      do_reset();
      load(8'd250);
      load(8'd20);
      chk("sat", balance, 255);

      // load ignored in GRANT, then FAILED_TRAN
      do_reset();
      load(8'd10);
      go_grant(3'd3);
      credit_load = 1'b1;
      credit_amt  = 8'd5;
      tick();
      credit_load = 1'b0;
      chk("grant_load_bal", balance, 10);
      chk("grant_load_valid", valid_tran, 1);
      failed_tran = 1'b1;
      tick();
      failed_tran = 1'b0;
      chk("fail_valid", valid_tran, 0);
      chk("fail_balance", balance, 10);
      chk("fail_decl", declined, 0);
      card_out();

      // GRANT timeout: VALID_TRAN held GRANT_TMO cycles
      go_grant(3'd3);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("gtmo_hold", valid_tran, 1);
      end
      tick();
      chk("gtmo_valid", valid_tran, 0);
      chk("gtmo_decl", declined, 1);
      tick();
      chk("gtmo_decl_end", declined, 0);
      chk("gtmo_balance", balance, 10);
      card_out();

      // VEND wins over FAILED_TRAN
      go_grant(3'd3);
      vend        = 1'b1;
      failed_tran = 1'b1;
      tick();
      vend        = 1'b0;
      failed_tran = 1'b0;
      chk("both_balance", balance, 7);
      card_out();

      // COST timeout in CARD_WAIT
      card_in = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("ctmo_wait", declined, 0);
      end
      tick();
      chk("ctmo_decl", declined, 1);
      chk("ctmo_busy", busy, 1);
      card_out();

      // card removed during AUTH
      card_in = 1'b1;
      tick();
      cost = 3'd2;
      tick();
      tick();
      card_in = 1'b0;
      cost    = 3'd0;
      tick();
      chk("abort_busy", busy, 0);
      chk("abort_decl", declined, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort_valid", valid_tran, 0);
      end
      chk("abort_balance", balance, 7);

      // async reset mid-GRANT
      go_grant(3'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", valid_tran, 0);
      chk("arst_balance", balance, 0);
      chk("arst_busy", busy, 0);
      do_reset();

`ifdef TXN_COUNT_EN
      chk("txn_rst", txn_count, 0);
      load(8'd20);
      for (int i = 0; i < 3; i++) begin
         go_grant(3'd1);
         vend = 1'b1;
         tick();
         vend = 1'b0;
         card_out();
      end
      chk("txn_three", txn_count, 3);
      go_grant(3'd1);
      vend    = 1'b1;
      txn_clr = 1'b1;
      tick();
      vend    = 1'b0;
      txn_clr = 1'b0;
      chk("txn_clr", txn_count, 0);
      chk("txn_bal", balance, 16);
      card_out();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
